// File: rtl/digit_serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_pkg;

  // Operation sequencing: waiting, stepping through digits, result just committed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_serial_subtractor_digit.sv
// One DIGIT-bit slice of the subtractor: a plain ripple chain of full subtractors.
module sub_digit
  import sub_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] d,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  // Ripple the borrow bit by bit; borrow into the top bit is exported for overflow detection.
  always_comb begin
    c    = '0;
    d    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      d[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (~x[i] & y[i]) | (c[i] & ~(x[i] ^ y[i]));
    end
  end

  assign cout    = c[DIGIT];
  assign msb_cin = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_subtractor.sv
// Multi-cycle a - b - bin, DIGIT bits per clock, least significant digit first.
module digit_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $error("digit_serial_subtractor: DIGIT must satisfy 1 <= DIGIT <= WIDTH");
  end
  if (WIDTH % DIGIT != 0) begin : g_bad_ratio
    $error("digit_serial_subtractor: WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_d;
  logic             dig_cout;
  logic             dig_msb_cin;
  logic [WIDTH-1:0] part_next;

  // The low digit of each operand shift register is the one being worked on this cycle.
  sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x       (a_q[DIGIT-1:0]),
    .y       (b_q[DIGIT-1:0]),
    .cin     (borrow_q),
    .d       (dig_d),
    .cout    (dig_cout),
    .msb_cin (dig_msb_cin)
  );

  // New digit enters at the top so after N steps the partial result is aligned.
  assign part_next = WIDTH'({dig_d, part_q} >> DIGIT);

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign diff  = diff_q;
  assign bout  = bout_q;
  assign ovf   = ovf_q;

  // Next-state: step digits in RUN, commit on the last one, accept a new request whenever ready.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        part_d   = part_next;
        borrow_d = dig_cout;
        if (cnt_q == LAST) begin
          diff_d  = part_next;
          bout_d  = dig_cout;
          ovf_d   = dig_cout ^ dig_msb_cin;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ready && start) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bin;
      cnt_d    = '0;
      state_d  = RUN;
    end
  end

  // State and datapath registers; reset aborts any operation and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Directed and reference-checked bench for digit_serial_subtractor at DIGIT=4, 8 and 1 (WIDTH=8).
module tb_digit_serial_subtractor;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] expDiff;
    logic       expBout;
    logic       expOvf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] aIn = '0;
  logic [7:0] bIn = '0;
  logic       binIn = 1'b0;
  logic       startV [3];
  logic       readyV [3];
  logic       busyV  [3];
  logic       doneV  [3];
  logic [7:0] diffV  [3];
  logic       boutV  [3];
  logic       ovfV   [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Index 0: DIGIT=4 (latency 2); index 1: DIGIT=8 (latency 1); index 2: DIGIT=1 (latency 8).
  digit_serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(startV[0]), .a(aIn), .b(bIn), .bin(binIn),
    .ready(readyV[0]), .busy(busyV[0]), .done(doneV[0]),
    .diff(diffV[0]), .bout(boutV[0]), .ovf(ovfV[0]));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(startV[1]), .a(aIn), .b(bIn), .bin(binIn),
    .ready(readyV[1]), .busy(busyV[1]), .done(doneV[1]),
    .diff(diffV[1]), .bout(boutV[1]), .ovf(ovfV[1]));

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(startV[2]), .a(aIn), .b(bIn), .bin(binIn),
    .ready(readyV[2]), .busy(busyV[2]), .done(doneV[2]),
    .diff(diffV[2]), .bout(boutV[2]), .ovf(ovfV[2]));

  // One comparison: counts it, reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Waits (bounded) for ready, then presents one request across a single rising edge.
  task automatic applyStimulus(input int sel, input logic [7:0] av, input logic [7:0] bv, input logic bi);
    int guard = 0;
    while (!readyV[sel] && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!readyV[sel]) checkOutput("ready_wait", 32'(readyV[sel]), 32'd1);
    aIn = av; bIn = bv; binIn = bi;
    startV[sel] = 1'b1;
    @(posedge clk); #1;
    startV[sel] = 1'b0;
  endtask

  // Counts rising edges until done is seen, giving up after 40.
  task automatic waitDone(input int sel, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!doneV[sel] && lat < 40);
  endtask

  // Independent reference: {ovf, bout, diff} of a - b - bin over 8 bits.
  function automatic logic [9:0] refSub(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    logic [8:0] t;
    int s;
    t = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
    s = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    return {(s < -128 || s > 127), t[8], t[7:0]};
  endfunction

  initial begin
    vec_t vecs [7];
    int lat;
    int doneCount;
    logic [9:0] r;
    logic [7:0] ra, rb;
    logic rbin;

    vecs[0] = '{8'h35, 8'h17, 1'b0, 8'h1E, 1'b0, 1'b0};
    vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};

    for (int i = 0; i < 3; i++) startV[i] = 1'b0;

    // Reset state
    #3;
    checkOutput("rst_diff",  32'(diffV[0]),  32'h0);
    checkOutput("rst_bout",  32'(boutV[0]),  32'h0);
    checkOutput("rst_ovf",   32'(ovfV[0]),   32'h0);
    checkOutput("rst_done",  32'(doneV[0]),  32'h0);
    checkOutput("rst_ready", 32'(readyV[0]), 32'h1);
    checkOutput("rst_busy",  32'(busyV[0]),  32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table on the DIGIT=4 build
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, vecs[i].a, vecs[i].b, vecs[i].bin);
      checkOutput($sformatf("v%0d_busy", i), 32'(busyV[0]), 32'h1);
      waitDone(0, lat);
      checkOutput($sformatf("v%0d_lat", i),   32'(lat),         32'd2);
      checkOutput($sformatf("v%0d_diff", i),  32'(diffV[0]),    32'(vecs[i].expDiff));
      checkOutput($sformatf("v%0d_bout", i),  32'(boutV[0]),    32'(vecs[i].expBout));
      checkOutput($sformatf("v%0d_ovf", i),   32'(ovfV[0]),     32'(vecs[i].expOvf));
      checkOutput($sformatf("v%0d_ready", i), 32'(readyV[0]),   32'h1);
    end
    @(posedge clk); #1;
    checkOutput("idle_done", 32'(doneV[0]), 32'h0);
    checkOutput("idle_hold", 32'(diffV[0]), 32'h4B);

    // start pulsed during RUN with other operands is ignored
    applyStimulus(0, 8'h35, 8'h17, 1'b0);
    aIn = 8'h11; bIn = 8'h22; binIn = 1'b1;
    startV[0] = 1'b1;
    @(posedge clk); #1;
    startV[0] = 1'b0;
    checkOutput("ign_hold", 32'(diffV[0]), 32'h4B);
    waitDone(0, lat);
    checkOutput("ign_lat",  32'(lat),      32'd1);
    checkOutput("ign_diff", 32'(diffV[0]), 32'h1E);
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (doneV[0]) doneCount++;
    end
    checkOutput("ign_single_done", 32'(doneCount), 32'd0);

    // start held through DONE: back-to-back acceptance
    applyStimulus(0, 8'h10, 8'h20, 1'b0);
    aIn = 8'h35; bIn = 8'h17; binIn = 1'b0;
    startV[0] = 1'b1;
    waitDone(0, lat);
    checkOutput("b2b_lat1",  32'(lat),      32'd2);
    checkOutput("b2b_diff1", 32'(diffV[0]), 32'hF0);
    checkOutput("b2b_bout1", 32'(boutV[0]), 32'h1);
    @(posedge clk); #1;
    startV[0] = 1'b0;
    checkOutput("b2b_reaccept_busy", 32'(busyV[0]), 32'h1);
    checkOutput("b2b_reaccept_done", 32'(doneV[0]), 32'h0);
    checkOutput("b2b_hold",          32'(diffV[0]), 32'hF0);
    waitDone(0, lat);
    checkOutput("b2b_lat2",  32'(lat),      32'd2);
    checkOutput("b2b_diff2", 32'(diffV[0]), 32'h1E);
    checkOutput("b2b_bout2", 32'(boutV[0]), 32'h0);

    // Reset mid-RUN: outputs clear at once, no done, then a fresh op completes
    applyStimulus(0, 8'h80, 8'h01, 1'b0);
    checkOutput("abort_prev", 32'(diffV[0]), 32'h1E);
    rst = 1'b1;
    #1;
    checkOutput("abort_diff",  32'(diffV[0]),  32'h0);
    checkOutput("abort_bout",  32'(boutV[0]),  32'h0);
    checkOutput("abort_ovf",   32'(ovfV[0]),   32'h0);
    checkOutput("abort_busy",  32'(busyV[0]),  32'h0);
    checkOutput("abort_ready", 32'(readyV[0]), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (doneV[0]) doneCount++;
    end
    checkOutput("abort_no_done", 32'(doneCount), 32'd0);
    applyStimulus(0, 8'h80, 8'h01, 1'b0);
    waitDone(0, lat);
    checkOutput("fresh_lat",  32'(lat),      32'd2);
    checkOutput("fresh_diff", 32'(diffV[0]), 32'h7F);
    checkOutput("fresh_ovf",  32'(ovfV[0]),  32'h1);

    // DIGIT=8 and DIGIT=1 builds against the reference
    for (int sel = 1; sel < 3; sel++) begin
      for (int k = 0; k < 8; k++) begin
        ra   = 8'($urandom_range(0, 255));
        rb   = 8'($urandom_range(0, 255));
        rbin = 1'($urandom_range(0, 1));
        if (k == 0) begin ra = 8'h00; rb = 8'hFF; rbin = 1'b1; end
        if (k == 1) begin ra = 8'h7F; rb = 8'h80; rbin = 1'b0; end
        r = refSub(ra, rb, rbin);
        applyStimulus(sel, ra, rb, rbin);
        waitDone(sel, lat);
        checkOutput($sformatf("d%0d_k%0d_lat", sel, k),  32'(lat),         (sel == 1) ? 32'd1 : 32'd8);
        checkOutput($sformatf("d%0d_k%0d_diff", sel, k), 32'(diffV[sel]),  32'(r[7:0]));
        checkOutput($sformatf("d%0d_k%0d_bout", sel, k), 32'(boutV[sel]),  32'(r[8]));
        checkOutput($sformatf("d%0d_k%0d_ovf", sel, k),  32'(ovfV[sel]),   32'(r[9]));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
